// File: rtl/thor2022_reb_seqnum.sv
// rtl/thor2022_reb_seqnum.sv - REB sequence-number manager.
// Keeps valid entries ranked 0..count-1 (oldest = 0) across allocs, retires and stomps.
module thor2022_reb_seqnum #(
  parameter int REB_ENTRIES = 6,
  parameter int NSLOT       = 8,
  parameter int SNW         = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 alloc0_v_i,
  input  logic [2:0]           alloc0_idx_i,
  input  logic                 alloc1_v_i,
  input  logic [2:0]           alloc1_idx_i,
  input  logic                 retire_v_i,
  input  logic [2:0]           retire_idx_i,
  input  logic [NSLOT-1:0]     stomp_i,
  output logic [NSLOT*SNW-1:0] sns_o,
  output logic [NSLOT-1:0]     valid_o,
  output logic [2:0]           head_o,
  output logic [3:0]           count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
);

  logic [SNW-1:0]   sns_q [NSLOT];
  logic [SNW-1:0]   sns_d [NSLOT];
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [2:0]       head_q, head_d;
  logic [3:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;

  logic [NSLOT-1:0] retire_oh, freed, surv, a0_oh, a1_oh;
  logic [SNW-1:0]   s_cnt, a1_sns, rank;
  logic             a0_ok, a1_ok, ret_err;

  always_comb begin
    retire_oh = '0;
    a0_oh     = '0;
    a1_oh     = '0;
    s_cnt     = '0;
    rank      = '0;
    count_d   = '0;
    head_d    = 3'd7;

    for (int i = 0; i < NSLOT; i++) begin
      retire_oh[i] = retire_v_i && (int'(retire_idx_i) == i) && (i < REB_ENTRIES);
    end
    freed = (stomp_i | retire_oh) & valid_q;
    surv  = valid_q & ~freed;
    for (int i = 0; i < NSLOT; i++) begin
      s_cnt = s_cnt + {{(SNW-1){1'b0}}, surv[i]};
    end

    // A slot being freed this cycle may be reused; only survivors block allocation.
    a0_ok = alloc0_v_i && (int'(alloc0_idx_i) < REB_ENTRIES) && !surv[alloc0_idx_i];
    a1_ok = alloc1_v_i && (int'(alloc1_idx_i) < REB_ENTRIES) && !surv[alloc1_idx_i] &&
            !(a0_ok && (alloc1_idx_i == alloc0_idx_i));
    for (int i = 0; i < NSLOT; i++) begin
      a0_oh[i] = a0_ok && (int'(alloc0_idx_i) == i);
      a1_oh[i] = a1_ok && (int'(alloc1_idx_i) == i);
    end
    a1_sns = a0_ok ? s_cnt + {{(SNW-1){1'b0}}, 1'b1} : s_cnt;

    for (int i = 0; i < NSLOT; i++) begin
      rank = '0;
      for (int j = 0; j < NSLOT; j++) begin
        if (surv[j] && (sns_q[j] < sns_q[i])) rank = rank + {{(SNW-1){1'b0}}, 1'b1};
      end
      if (a0_oh[i])      sns_d[i] = s_cnt;
      else if (a1_oh[i]) sns_d[i] = a1_sns;
      else if (surv[i])  sns_d[i] = rank;
      else               sns_d[i] = '1;
    end
    valid_d = surv | a0_oh | a1_oh;

    ret_err = retire_v_i && ((int'(retire_idx_i) >= REB_ENTRIES) || !valid_q[retire_idx_i]);
    err_d   = err_q | ret_err | (alloc0_v_i && !a0_ok) | (alloc1_v_i && !a1_ok);

    if (flush_i) begin
      valid_d = '0;
      err_d   = err_q;
      for (int i = 0; i < NSLOT; i++) sns_d[i] = '1;
    end

    for (int i = NSLOT - 1; i >= 0; i--) begin
      count_d = count_d + {3'b000, valid_d[i]};
      if (valid_d[i] && (sns_d[i] == '0)) head_d = 3'(i);
    end
    full_d  = (int'(count_d) == REB_ENTRIES);
    empty_d = (count_d == 4'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSLOT; i++) sns_q[i] <= '1;
      valid_q <= '0;
      head_q  <= 3'd7;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) sns_q[i] <= sns_d[i];
      valid_q <= valid_d;
      head_q  <= head_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) sns_o[i*SNW +: SNW] = sns_q[i];
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign err_o   = err_q;

  // Valid ranks must be distinct, below count, and number exactly count.
  logic inv_ok;
  int   inv_cnt;
  always_comb begin
    inv_ok  = 1'b1;
    inv_cnt = 0;
    for (int i = 0; i < NSLOT; i++) begin
      if (valid_q[i]) begin
        inv_cnt = inv_cnt + 1;
        if (int'(sns_q[i]) >= int'(count_q)) inv_ok = 1'b0;
        for (int j = 0; j < NSLOT; j++) begin
          if ((j != i) && valid_q[j] && (sns_q[j] == sns_q[i])) inv_ok = 1'b0;
        end
      end
    end
    if (inv_cnt != int'(count_q)) inv_ok = 1'b0;
  end

  always @(posedge clk_i) begin
    if (rst_ni) assert (inv_ok);
  end

endmodule

// File: tb/tb_thor2022_reb_seqnum.sv
// tb/tb_thor2022_reb_seqnum.sv - directed self-checking bench for thor2022_reb_seqnum.
module tb_thor2022_reb_seqnum;

  localparam logic [5:0] X = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        a0_v = 1'b0, a1_v = 1'b0, r_v = 1'b0;
  logic [2:0]  a0_i = '0, a1_i = '0, r_i = '0;
  logic [7:0]  stomp = '0;
  logic [47:0] sns;
  logic [7:0]  valid;
  logic [2:0]  head;
  logic [3:0]  count;
  logic        full, empty, err;

  int checks = 0;
  int errors = 0;

  thor2022_reb_seqnum dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc0_v_i(a0_v), .alloc0_idx_i(a0_i),
    .alloc1_v_i(a1_v), .alloc1_idx_i(a1_i),
    .retire_v_i(r_v), .retire_idx_i(r_i),
    .stomp_i(stomp),
    .sns_o(sns), .valid_o(valid), .head_o(head), .count_o(count),
    .full_o(full), .empty_o(empty), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic v0, input logic [2:0] i0, input logic v1, input logic [2:0] i1,
                       input logic rv, input logic [2:0] ri, input logic [7:0] st, input logic fl);
    a0_v = v0; a0_i = i0; a1_v = v1; a1_i = i1;
    r_v = rv; r_i = ri; stomp = st; flush = fl;
    @(posedge clk); #1;
    a0_v = 0; a1_v = 0; r_v = 0; stomp = '0; flush = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(posedge clk); #1;
    checks += 7;
    if (valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want 00", valid); end
    if (sns !== {8{X}}) begin errors++; $display("FAIL reset_sns got %h want all-ones", sns); end
    if (head !== 3'd7) begin errors++; $display("FAIL reset_head got %0d want 7", head); end
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1;
  endtask

  task automatic test_pair_alloc();
    drive(1, 3'd2, 1, 3'd4, 0, 3'd0, 8'h00, 0);
    checks += 5;
    if (sns !== {X, X, X, 6'd1, X, 6'd0, X, X}) begin errors++; $display("FAIL pair_sns got %h", sns); end
    if (valid !== 8'h14) begin errors++; $display("FAIL pair_valid got %h want 14", valid); end
    if (head !== 3'd2) begin errors++; $display("FAIL pair_head got %0d want 2", head); end
    if (count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d want 2", count); end
    if (empty !== 1'b0) begin errors++; $display("FAIL pair_empty got %b want 0", empty); end
  endtask

  task automatic test_full();
    apply_reset();
    drive(1, 3'd0, 1, 3'd1, 0, 3'd0, 8'h00, 0);
    drive(1, 3'd2, 1, 3'd3, 0, 3'd0, 8'h00, 0);
    drive(1, 3'd4, 1, 3'd5, 0, 3'd0, 8'h00, 0);
    checks += 4;
    if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", full); end
    if (count !== 4'd6) begin errors++; $display("FAIL full_count got %0d want 6", count); end
    if (sns !== {X, X, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL full_sns got %h", sns); end
    if (err !== 1'b0) begin errors++; $display("FAIL full_err_pre got %b want 0", err); end
    drive(1, 3'd1, 0, 3'd0, 0, 3'd0, 8'h00, 0);
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL full_alloc_err got %b want 1", err); end
    if (sns !== {X, X, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL full_sns_hold got %h", sns); end
    if (count !== 4'd6) begin errors++; $display("FAIL full_count_hold got %0d want 6", count); end
  endtask

  task automatic test_retire_realloc();
    apply_reset();
    drive(1, 3'd0, 1, 3'd1, 0, 3'd0, 8'h00, 0);
    drive(1, 3'd2, 1, 3'd3, 0, 3'd0, 8'h00, 0);
    checks += 1;
    if (sns !== {X, X, X, X, 6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL four_sns got %h", sns); end
    drive(1, 3'd0, 0, 3'd0, 1, 3'd0, 8'h00, 0);
    checks += 4;
    if (sns !== {X, X, X, X, 6'd2, 6'd1, 6'd0, 6'd3}) begin errors++; $display("FAIL realloc_sns got %h", sns); end
    if (head !== 3'd1) begin errors++; $display("FAIL realloc_head got %0d want 1", head); end
    if (count !== 4'd4) begin errors++; $display("FAIL realloc_count got %0d want 4", count); end
    if (err !== 1'b0) begin errors++; $display("FAIL realloc_err got %b want 0", err); end
    drive(0, 3'd0, 0, 3'd0, 1, 3'd2, 8'h00, 0);
    checks += 3;
    if (sns !== {X, X, X, X, 6'd1, X, 6'd0, 6'd2}) begin errors++; $display("FAIL nonhead_sns got %h", sns); end
    if (count !== 4'd3) begin errors++; $display("FAIL nonhead_count got %0d want 3", count); end
    if (err !== 1'b0) begin errors++; $display("FAIL nonhead_err got %b want 0", err); end
  endtask

  task automatic test_stomp();
    apply_reset();
    drive(1, 3'd0, 1, 3'd1, 0, 3'd0, 8'h00, 0);
    drive(1, 3'd2, 1, 3'd3, 0, 3'd0, 8'h00, 0);
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 8'h06, 0);
    checks += 4;
    if (sns !== {X, X, X, X, 6'd1, X, X, 6'd0}) begin errors++; $display("FAIL stomp_sns got %h", sns); end
    if (count !== 4'd2) begin errors++; $display("FAIL stomp_count got %0d want 2", count); end
    if (valid !== 8'h09) begin errors++; $display("FAIL stomp_valid got %h want 09", valid); end
    if (head !== 3'd0) begin errors++; $display("FAIL stomp_head got %0d want 0", head); end
  endtask

  task automatic test_retire_stomp_same();
    drive(0, 3'd0, 1, 3'd5, 1, 3'd3, 8'h08, 0);
    checks += 4;
    if (sns !== {X, X, 6'd1, X, X, X, X, 6'd0}) begin errors++; $display("FAIL rs_sns got %h", sns); end
    if (valid !== 8'h21) begin errors++; $display("FAIL rs_valid got %h want 21", valid); end
    if (count !== 4'd2) begin errors++; $display("FAIL rs_count got %0d want 2", count); end
    if (err !== 1'b0) begin errors++; $display("FAIL rs_err got %b want 0", err); end
  endtask

  task automatic test_errors();
    apply_reset();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 8'h00, 0);
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 8'hC2, 0);
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL stomp_invalid_err got %b want 0", err); end
    if (count !== 4'd1) begin errors++; $display("FAIL stomp_invalid_count got %0d want 1", count); end
    drive(0, 3'd0, 0, 3'd0, 1, 3'd2, 8'h00, 0);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL retire_invalid_err got %b want 1", err); end
    if (count !== 4'd1) begin errors++; $display("FAIL retire_invalid_count got %0d want 1", count); end
    apply_reset();
    drive(1, 3'd6, 0, 3'd0, 0, 3'd0, 8'h00, 0);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL alloc_range_err got %b want 1", err); end
    if (count !== 4'd0) begin errors++; $display("FAIL alloc_range_count got %0d want 0", count); end
    apply_reset();
    drive(1, 3'd3, 1, 3'd3, 0, 3'd0, 8'h00, 0);
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL dup_alloc_err got %b want 1", err); end
    if (count !== 4'd1) begin errors++; $display("FAIL dup_alloc_count got %0d want 1", count); end
    if (sns !== {X, X, X, X, 6'd0, X, X, X}) begin errors++; $display("FAIL dup_alloc_sns got %h", sns); end
    apply_reset();
    drive(1, 3'd7, 1, 3'd2, 0, 3'd0, 8'h00, 0);
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL a1_only_err got %b want 1", err); end
    if (sns !== {X, X, X, X, X, 6'd0, X, X}) begin errors++; $display("FAIL a1_only_sns got %h", sns); end
    if (head !== 3'd2) begin errors++; $display("FAIL a1_only_head got %0d want 2", head); end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1, 3'd0, 1, 3'd1, 0, 3'd0, 8'h00, 0);
    drive(0, 3'd0, 0, 3'd0, 1, 3'd4, 8'h00, 0);
    drive(1, 3'd2, 1, 3'd3, 0, 3'd0, 8'h00, 1);
    checks += 6;
    if (valid !== 8'h00) begin errors++; $display("FAIL flush_valid got %h want 00", valid); end
    if (sns !== {8{X}}) begin errors++; $display("FAIL flush_sns got %h", sns); end
    if (head !== 3'd7) begin errors++; $display("FAIL flush_head got %0d want 7", head); end
    if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    if (err !== 1'b1) begin errors++; $display("FAIL flush_err_hold got %b want 1", err); end
    drive(1, 3'd5, 0, 3'd0, 0, 3'd0, 8'h00, 0);
    checks += 2;
    if (head !== 3'd5) begin errors++; $display("FAIL post_flush_head got %0d want 5", head); end
    if (sns !== {X, X, 6'd0, X, X, X, X, X}) begin errors++; $display("FAIL post_flush_sns got %h", sns); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    checks += 5;
    if (valid !== 8'h00) begin errors++; $display("FAIL async_valid got %h want 00", valid); end
    if (sns !== {8{X}}) begin errors++; $display("FAIL async_sns got %h", sns); end
    if (head !== 3'd7) begin errors++; $display("FAIL async_head got %0d want 7", head); end
    if (empty !== 1'b1) begin errors++; $display("FAIL async_empty got %b want 1", empty); end
    if (err !== 1'b0) begin errors++; $display("FAIL async_err got %b want 0", err); end
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_pair_alloc();
    test_full();
    test_retire_realloc();
    test_stomp();
    test_retire_stomp_same();
    test_errors();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
